fetch_queue: RTL

- Instruction-fetch stage that sits directly upstream of decode and drives its fe_to_de_s input register.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions in a small FIFO.
- Handles decode stalls and execute-stage redirects, dropping stale in-flight responses after a redirect.

---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch stage: PC, credit-limited imem requests,
//             response FIFO and registered fe_to_de hand-off to decode.
//  Revision : 1.0
// ============================================================================
`default_nettype none

typedef struct packed {
    logic [31:0] pc_value;
    logic [31:0] instruction_value;
    logic        pc_r;
} fe_to_de_s;

module fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output fe_to_de_s   fe_to_de
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 2;

    logic [31:0]        r_pc;
    logic [31:0]        r_ifq [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_ifq_wr;
    logic [c_PTR_W-1:0] r_ifq_rd;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [31:0]        r_buf_pc    [BUF_DEPTH];
    logic [31:0]        r_buf_instr [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_buf_wr;
    logic [c_PTR_W-1:0] r_buf_rd;
    logic [c_CNT_W-1:0] r_count;
    fe_to_de_s          r_fe_to_de;

    logic [c_SUM_W-1:0] w_credit_sum;
    logic [31:0]        w_redirect_pc;
    logic               w_req_fire;
    logic               w_rsp_keep;
    logic               w_rsp_drop;
    logic               w_pop;

    // Stale responses still owed by memory hold a credit until they drain.
    assign w_credit_sum   = c_SUM_W'(r_inflight) + c_SUM_W'(r_count) + c_SUM_W'(r_drop_cnt);
    assign imem_req_valid = !rst && !redirect && (w_credit_sum < c_SUM_W'(BUF_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_drop     = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect;
    assign w_pop          = !redirect && !stall && (r_count != '0);
    assign fe_to_de       = r_fe_to_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= w_redirect_pc;
        end else if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifq_wr   <= '0;
            r_ifq_rd   <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            // Everything still owed becomes stale; a response landing now is one of them.
            r_ifq_wr   <= '0;
            r_ifq_rd   <= '0;
            r_inflight <= '0;
            r_drop_cnt <= r_drop_cnt + r_inflight - c_CNT_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) r_ifq_wr <= r_ifq_wr + c_PTR_W'(1);
            if (w_rsp_keep) r_ifq_rd <= r_ifq_rd + c_PTR_W'(1);
            r_inflight <= r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp_keep);
            r_drop_cnt <= r_drop_cnt - c_CNT_W'(w_rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_wr <= '0;
            r_buf_rd <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_buf_wr <= '0;
            r_buf_rd <= '0;
            r_count  <= '0;
        end else begin
            if (w_rsp_keep) r_buf_wr <= r_buf_wr + c_PTR_W'(1);
            if (w_pop)      r_buf_rd <= r_buf_rd + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_rsp_keep) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req_fire) begin
            r_ifq[r_ifq_wr] <= r_pc;
        end
        if (!rst && w_rsp_keep) begin
            r_buf_pc[r_buf_wr]    <= r_ifq[r_ifq_rd];
            r_buf_instr[r_buf_wr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fe_to_de.pc_value          <= '0;
            r_fe_to_de.instruction_value <= NOP_INSTR;
            r_fe_to_de.pc_r              <= 1'b1;
        end else if (redirect) begin
            r_fe_to_de.instruction_value <= NOP_INSTR;
            r_fe_to_de.pc_r              <= 1'b1;
        end else if (!stall) begin
            if (r_count != '0) begin
                r_fe_to_de.pc_value          <= r_buf_pc[r_buf_rd];
                r_fe_to_de.instruction_value <= r_buf_instr[r_buf_rd];
                r_fe_to_de.pc_r              <= 1'b0;
            end else begin
                r_fe_to_de.instruction_value <= NOP_INSTR;
                r_fe_to_de.pc_r              <= 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_rsp_keep |-> (r_count < c_CNT_W'(BUF_DEPTH)));

endmodule

`default_nettype wire
